sel_mux_rr: RTL and testbench

Registered N-channel, M-bit channel selector with per-channel valid/ready handshaking and a one-deep output register. A runtime mode input chooses between fixed selection by index and round-robin arbitration across requesting channels. The block sits between parallel producers packed on one N*M bus and a single downstream consumer, replacing purely combinational slice selection wherever backpressure and fairness are needed.

---
 rtl/sel_mux_rr_pkg.sv | 18 +
 rtl/sel_mux_rr_if.sv | 32 +++
 rtl/sel_mux_rr_rr_pick.sv | 32 +++
 rtl/sel_mux_rr.sv | 90 +++++++++
 tb/tb_sel_mux_rr.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/sel_mux_rr_pkg.sv
// Shared constants and helpers for the sel_mux_rr channel selector.
package sel_mux_rr_pkg;

   // ceil(log2(n)) with a floor of 1, so a single-channel selector still
   // gets a 1-bit index.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/sel_mux_rr_if.sv
// Bus bundle between parallel producers / downstream consumer and sel_mux_rr.
// The slave modport is the selector's view; the master modport is the view of
// whatever drives the producers and the consumer.
interface sel_mux_rr_if
   import sel_mux_rr_pkg::*;
#(
   parameter int N = 8,
   parameter int M = 8
);
   localparam int SELW = clog2_min1(N);

   logic [N*M-1:0]  i_data;
   logic [N-1:0]    i_valid;
   logic [N-1:0]    o_ready;
   logic            i_mode;
   logic [SELW-1:0] i_sel;
   logic [M-1:0]    o_data;
   logic [SELW-1:0] o_ch;
   logic            o_valid;
   logic            i_ready;

   modport slave (
      input  i_data, i_valid, i_mode, i_sel, i_ready,
      output o_ready, o_data, o_ch, o_valid
   );

   modport master (
      output i_data, i_valid, i_mode, i_sel, i_ready,
      input  o_ready, o_data, o_ch, o_valid
   );

endinterface

// File: rtl/sel_mux_rr_rr_pick.sv
// Rotating-priority request picker: returns the first requesting channel found
// when searching base+1, base+2, ... modulo N. Purely combinational.
module sel_mux_rr_rr_pick #(
   parameter int N    = 8,
   parameter int SELW = 3
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] base,
   output logic [SELW-1:0] gnt_idx,
   output logic            gnt_any
);

   // Doubling the request vector lets a plain right shift perform the modulo-N
   // rotation: bit j of rot is req[(base+1+j) mod N] because base < N.
   logic [2*N-1:0] req2;
   logic [N-1:0]   rot;

   assign req2 = {req, req};
   assign rot  = N'(req2 >> (int'(base) + 1));

   // Lowest set bit of the rotated vector is the nearest requester after base.
   always_comb begin
      gnt_idx = '0;
      gnt_any = |req;
      for (int j = N - 1; j >= 0; j--) begin
         if (rot[j]) begin
            gnt_idx = SELW'((int'(base) + 1 + j) % N);
         end
      end
   end

endmodule

// File: rtl/sel_mux_rr.sv
// Registered N-channel selector with valid/ready per channel, a one-deep output
// register, and a runtime choice of fixed-index or round-robin selection.
module sel_mux_rr
   import sel_mux_rr_pkg::*;
#(
   parameter int N = 8,
   parameter int M = 8
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   sel_mux_rr_if.slave bus
);

   localparam int SELW = clog2_min1(N);
   // Request vector padded to the full index range so an out-of-range i_sel
   // simply reads a zero and never grants.
   localparam int PADW = 1 << SELW;

   logic [M-1:0]    ch_data [N];
   logic [PADW-1:0] valid_pad;
   logic [SELW-1:0] rr_idx;
   logic            rr_any;
   logic [SELW-1:0] gnt_idx;
   logic            gnt_ok;
   logic            load_en;
   logic            take;

   logic [M-1:0]    data_reg;
   logic [SELW-1:0] ch_reg;
   logic            valid_reg;
   logic [SELW-1:0] ptr_reg;

   for (genvar gi = 0; gi < N; gi++) begin : g_ch
      assign ch_data[gi]     = bus.i_data[gi*M +: M];
      assign bus.o_ready[gi] = take && (gnt_idx == SELW'(gi));
   end

   assign valid_pad = PADW'(bus.i_valid);

   sel_mux_rr_rr_pick #(
      .N    (N),
      .SELW (SELW)
   ) u_rr_pick (
      .req     (bus.i_valid),
      .base    (ptr_reg),
      .gnt_idx (rr_idx),
      .gnt_any (rr_any)
   );

   // Mode mux: fixed index or round-robin pick.
   always_comb begin
      gnt_idx = bus.i_sel;
      gnt_ok  = valid_pad[bus.i_sel];
      if (bus.i_mode == MODE_RR) begin
         gnt_idx = rr_idx;
         gnt_ok  = rr_any;
      end
   end

   // Output register can accept when empty or being drained this cycle;
   // nothing is accepted while reset is asserted.
   assign load_en = !valid_reg || bus.i_ready;
   assign take    = i_rst_n && load_en && gnt_ok;

   // Output register and round-robin pointer.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         data_reg  <= '0;
         ch_reg    <= '0;
         valid_reg <= 1'b0;
         ptr_reg   <= SELW'(N - 1);
      end else if (load_en) begin
         if (take) begin
            data_reg  <= ch_data[gnt_idx];
            ch_reg    <= gnt_idx;
            valid_reg <= 1'b1;
            if (bus.i_mode == MODE_RR) begin
               ptr_reg <= gnt_idx;
            end
         end else begin
            valid_reg <= 1'b0;
         end
      end
   end

   assign bus.o_data  = data_reg;
   assign bus.o_ch    = ch_reg;
   assign bus.o_valid = valid_reg;

endmodule

// File: tb/tb_sel_mux_rr.sv
// Directed bench for sel_mux_rr: an 8-channel instance for the main scenarios
// and a 10-channel instance for the non-power-of-2 index boundary.
module tb_sel_mux_rr;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   sel_mux_rr_if #(.N(8),  .M(8)) a_if ();
   sel_mux_rr_if #(.N(10), .M(8)) b_if ();

   sel_mux_rr #(.N(8), .M(8)) dut_a (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (a_if)
   );

   sel_mux_rr #(.N(10), .M(8)) dut_b (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (b_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic v, input logic [7:0] d, input logic [2:0] ch);
      chk({tag, ".valid"}, a_if.o_valid, v);
      chk({tag, ".data"},  a_if.o_data,  d);
      chk({tag, ".ch"},    a_if.o_ch,    ch);
      $display("step %s: valid=%0d data=%02h ch=%0d ready=%02h", tag,
               a_if.o_valid, a_if.o_data, a_if.o_ch, a_if.o_ready);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      a_if.i_valid = '0; a_if.i_mode = 1'b0; a_if.i_sel = '0; a_if.i_ready = 1'b1;
      b_if.i_valid = '0; b_if.i_mode = 1'b0; b_if.i_sel = '0; b_if.i_ready = 1'b1;
      for (int k = 0; k < 8; k++)  a_if.i_data[k*8 +: 8] = 8'h10 + 8'(k);
      for (int k = 0; k < 10; k++) b_if.i_data[k*8 +: 8] = 8'h20 + 8'(k);

      // Reset held for 3 cycles, then idle.
      for (int c = 0; c < 3; c++) begin
         tick();
         chk_a("rst", 1'b0, 8'h00, 3'd0);
         chk("rst.ready", a_if.o_ready, 8'h00);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         chk_a("idle", 1'b0, 8'h00, 3'd0);
         chk("idle.ready", a_if.o_ready, 8'h00);
      end

      // Fixed select of channel 3 with every channel requesting.
      a_if.i_mode = 1'b0; a_if.i_sel = 3'd3; a_if.i_valid = 8'hFF;
      #1 chk("fix.ready0", a_if.o_ready, 8'h08);
      tick();
      chk_a("fix1", 1'b1, 8'h13, 3'd3);
      chk("fix.ready1", a_if.o_ready, 8'h08);
      tick();
      chk_a("fix2", 1'b1, 8'h13, 3'd3);

      // No requests with the consumer ready: register empties, data holds.
      a_if.i_valid = 8'h00;
      #1 chk("empty.ready", a_if.o_ready, 8'h00);
      tick();
      chk_a("empty", 1'b0, 8'h13, 3'd3);

      // Round-robin over channels 0,2,5,7 from the reset pointer.
      a_if.i_mode = 1'b1; a_if.i_valid = 8'b1010_0101;
      #1 chk("rr.ready0", a_if.o_ready, 8'h01);
      tick(); chk_a("rr0", 1'b1, 8'h10, 3'd0);
      chk("rr.ready1", a_if.o_ready, 8'h04);
      tick(); chk_a("rr2", 1'b1, 8'h12, 3'd2);
      tick(); chk_a("rr5", 1'b1, 8'h15, 3'd5);
      tick(); chk_a("rr7", 1'b1, 8'h17, 3'd7);
      tick(); chk_a("rr0b", 1'b1, 8'h10, 3'd0);
      tick(); chk_a("rr2b", 1'b1, 8'h12, 3'd2);

      // Asynchronous reset between edges while the register is full.
      #3 rst_n = 1'b0;
      #1;
      chk_a("arst", 1'b0, 8'h00, 3'd0);
      chk("arst.ready", a_if.o_ready, 8'h00);
      tick();
      chk_a("arst_hold", 1'b0, 8'h00, 3'd0);
      chk("arst_hold.ready", a_if.o_ready, 8'h00);
      rst_n = 1'b1;

      // After release the pointer restarts: channel 0 first; then backpressure.
      a_if.i_valid = 8'hFF;
      #1 chk("post.ready", a_if.o_ready, 8'h01);
      tick();
      chk_a("bp0", 1'b1, 8'h10, 3'd0);
      a_if.i_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1 chk("bp.ready", a_if.o_ready, 8'h00);
         tick();
         chk_a("bp_hold", 1'b1, 8'h10, 3'd0);
      end
      a_if.i_ready = 1'b1;
      #1 chk("bp.release_ready", a_if.o_ready, 8'h02);
      tick();
      chk_a("bp_rel", 1'b1, 8'h11, 3'd1);

      // Mode switch: fixed channel 6 twice, then round-robin resumes after 1.
      a_if.i_mode = 1'b0; a_if.i_sel = 3'd6;
      tick(); chk_a("ms6a", 1'b1, 8'h16, 3'd6);
      tick(); chk_a("ms6b", 1'b1, 8'h16, 3'd6);
      a_if.i_mode = 1'b1;
      #1 chk("ms.ready", a_if.o_ready, 8'h04);
      tick(); chk_a("ms2", 1'b1, 8'h12, 3'd2);
      a_if.i_valid = 8'h00;

      // Ten-channel instance: highest legal index grants, out-of-range never does.
      b_if.i_mode = 1'b0; b_if.i_valid = 10'h3FF; b_if.i_sel = 4'd9;
      #1 chk("b.ready9", b_if.o_ready, 10'h200);
      tick();
      chk("b.ch9", b_if.o_ch, 4'd9);
      chk("b.data9", b_if.o_data, 8'h29);
      chk("b.valid9", b_if.o_valid, 1'b1);
      $display("step b9: valid=%0d data=%02h ch=%0d", b_if.o_valid, b_if.o_data, b_if.o_ch);
      b_if.i_sel = 4'd12;
      #1 chk("b.ready12", b_if.o_ready, 10'h000);
      tick();
      chk("b.valid12", b_if.o_valid, 1'b0);
      chk("b.ch12", b_if.o_ch, 4'd9);
      $display("step b12: valid=%0d data=%02h ch=%0d", b_if.o_valid, b_if.o_data, b_if.o_ch);

      // Round-robin wrap modulo 10 between channels 0 and 9.
      b_if.i_mode = 1'b1; b_if.i_valid = 10'b10_0000_0001;
      tick(); chk("b.rr0", b_if.o_ch, 4'd0);
      tick(); chk("b.rr9", b_if.o_ch, 4'd9);
      tick(); chk("b.rr0b", b_if.o_ch, 4'd0);
      chk("b.rr0b.data", b_if.o_data, 8'h20);
      $display("step b_rr: valid=%0d data=%02h ch=%0d", b_if.o_valid, b_if.o_data, b_if.o_ch);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
